// File: rtl/psum_streamer_pkg.sv
// Shared types and default sizes for the psum transmit streamer.
package psum_streamer_pkg;
  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int SIZE_W_DEF = 16;
  localparam int CH_W_DEF   = 8;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  // Width of a lane index, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/psum_lane_buf.sv
// LANES x DATA_W holding register for one input word, with a lane select mux.
module psum_lane_buf #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [LANES*DATA_W-1:0] word,
  input  logic [IDX_W-1:0]        sel,
  output logic [DATA_W-1:0]       lane
);
  logic [LANES-1:0][DATA_W-1:0] buf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (load) begin
      for (int k = 0; k < LANES; k++) buf_q[k] <= word[k*DATA_W +: DATA_W];
    end
  end

  assign lane = buf_q[sel];
endmodule

// File: rtl/psum_streamer.sv
// Serializes LANES-wide psum words into a channel-major one-psum-per-beat stream.
// Optional PSUM_STREAMER_LAST_EN adds plast_o marking the last psum of each channel.
module psum_streamer
  import psum_streamer_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [SIZE_W-1:0]       ofmap_size,
  input  logic [CH_W-1:0]         ifmap_ch,
  input  logic                    lane_valid_i,
  output logic                    lane_ready_o,
  input  logic [LANES*DATA_W-1:0] lane_psum_i,
  output logic [DATA_W-1:0]       psum_o,
  output logic                    pvalid_o,
  input  logic                    pready_i,
  output logic                    busy_o,
`ifdef PSUM_STREAMER_LAST_EN
  output logic                    plast_o,
`endif
  output logic                    done_o
);
  localparam int IDX_W = idx_w(LANES);

  state_t             state, state_nx;
  logic [SIZE_W-1:0]  size_q, pix_cnt;
  logic [CH_W-1:0]    ch_q, ch_cnt;
  logic [IDX_W-1:0]   lane_idx;
  logic [DATA_W-1:0]  lane_val;
  logic               xfer, row_end, word_end, frame_end, accept;

  assign row_end   = (pix_cnt == size_q);
  assign word_end  = (lane_idx == IDX_W'(LANES-1)) || row_end;
  assign frame_end = row_end && (ch_cnt == ch_q);
  assign xfer      = (state == SEND) && pready_i;
  assign accept    = lane_valid_i && lane_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Ready is offered during the word-ending beat so the next word follows with no bubble;
  // the frame-ending beat has no successor word, so nothing is taken then.
  always_comb begin
    state_nx     = state;
    lane_ready_o = 1'b0;
    case (state)
      IDLE: if (start_i) state_nx = LOAD;
      LOAD: begin
        lane_ready_o = 1'b1;
        if (lane_valid_i) state_nx = SEND;
      end
      SEND: if (pready_i && word_end) begin
        if (frame_end) begin
          state_nx = DONE;
        end else begin
          lane_ready_o = 1'b1;
          state_nx     = lane_valid_i ? SEND : LOAD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q   <= '0;
      ch_q     <= '0;
      pix_cnt  <= '0;
      ch_cnt   <= '0;
      lane_idx <= '0;
    end else if (state == IDLE && start_i) begin
      size_q   <= ofmap_size;
      ch_q     <= ifmap_ch;
      pix_cnt  <= '0;
      ch_cnt   <= '0;
      lane_idx <= '0;
    end else if (xfer) begin
      // A channel always restarts at lane 0; leftover lanes of a partial word are dropped.
      lane_idx <= word_end ? '0 : lane_idx + 1'b1;
      if (row_end) begin
        pix_cnt <= '0;
        ch_cnt  <= ch_cnt + 1'b1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  psum_lane_buf #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .word (lane_psum_i),
    .sel  (lane_idx),
    .lane (lane_val)
  );

  assign pvalid_o = (state == SEND);
  assign psum_o   = pvalid_o ? lane_val : '0;
  assign busy_o   = (state == LOAD) || (state == SEND);
  assign done_o   = (state == DONE);
`ifdef PSUM_STREAMER_LAST_EN
  assign plast_o  = pvalid_o && row_end;
`endif
endmodule

// File: tb/tb_psum_streamer.sv
// Directed bench for psum_streamer with a queue-based reference of the expected stream.
module tb_psum_streamer;
  localparam int LANES  = 4;
  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] ofmap_size = '0;
  logic [7:0]  ifmap_ch = '0;
  logic        lane_valid_i = 1'b0;
  logic        lane_ready_o;
  logic [31:0] lane_psum_i = '0;
  logic [7:0]  psum_o;
  logic        pvalid_o;
  logic        pready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        plast_o;

  psum_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .ofmap_size   (ofmap_size),
    .ifmap_ch     (ifmap_ch),
    .lane_valid_i (lane_valid_i),
    .lane_ready_o (lane_ready_o),
    .lane_psum_i  (lane_psum_i),
    .psum_o       (psum_o),
    .pvalid_o     (pvalid_o),
    .pready_i     (pready_i),
    .busy_o       (busy_o),
`ifdef PSUM_STREAMER_LAST_EN
    .plast_o      (plast_o),
`endif
    .done_o       (done_o)
  );

`ifndef PSUM_STREAMER_LAST_EN
  assign plast_o = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct { logic [7:0] val; logic last; } beat_t;

  int          total = 0, bad = 0;
  logic [31:0] words[$];
  beat_t       exp_q[$];
  bit          chk_en = 0, held = 0, exp_done = 0;
  logic [7:0]  held_val, first_val, last_val;
  int          beats, done_cnt, acc_cnt, plast_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] mkw(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: for each channel, pixels 0..size taken in lane order from consecutive words,
  // one fresh word sequence per channel; unused lanes of a channel's last word are skipped.
  function automatic void build_exp(input int size, input int ch);
    int    wpc;
    beat_t e;
    wpc = (size + LANES) / LANES;
    exp_q.delete();
    for (int c = 0; c <= ch; c++)
      for (int p = 0; p <= size; p++) begin
        e.val  = words[c*wpc + p/LANES][(p%LANES)*DATA_W +: DATA_W];
        e.last = (p == size);
        exp_q.push_back(e);
      end
  endfunction

  always @(negedge clk) begin
    if (!chk_en) begin
      held     = 0;
      exp_done = 0;
    end else begin
      chk("done_timing", done_o, exp_done);
      if (done_o) begin
        done_cnt++;
        chk("busy_at_done", busy_o, 1'b0);
      end
      exp_done = 0;
      if (pvalid_o) begin
        if (held) chk("hold_psum", psum_o, held_val);
        if (pready_i) begin
          held = 0;
          if (exp_q.size() == 0) begin
            chk("extra_beat", {24'd0, psum_o}, 32'hFFFF_FFFF);
          end else begin
            chk("psum", psum_o, exp_q[0].val);
`ifdef PSUM_STREAMER_LAST_EN
            chk("plast", plast_o, exp_q[0].last);
            if (plast_o) plast_cnt++;
`endif
            void'(exp_q.pop_front());
            if (beats == 0) first_val = psum_o;
            last_val = psum_o;
            beats++;
            if (exp_q.size() == 0) exp_done = 1;
          end
        end else begin
          held     = 1;
          held_val = psum_o;
        end
      end else if (held) begin
        chk("retract", pvalid_o, 1'b1);
        held = 0;
      end
    end
  end

  // pmode 1 toggles pready; rst_beat >= 0 aborts with reset once that many beats moved;
  // restart_cyc >= 0 pulses start_i (with a different size) mid-frame.
  task automatic run_frame(input int size, input int ch, input int pmode,
                           input int rst_beat, input int restart_cyc);
    int widx;
    bit acc, got;
    build_exp(size, ch);
    widx = 0; acc_cnt = 0; beats = 0; done_cnt = 0; plast_cnt = 0; got = 0;
    chk_en = 1;
    @(posedge clk); #1;
    ofmap_size   = 16'(size);
    ifmap_ch     = 8'(ch);
    start_i      = 1'b1;
    pready_i     = 1'b1;
    lane_valid_i = 1'b1;
    lane_psum_i  = words[0];
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      @(negedge clk);
      acc = lane_valid_i && lane_ready_o;
      if (done_o) got = 1;
      @(posedge clk); #1;
      if (acc) begin widx++; acc_cnt++; end
      start_i    = (cyc == restart_cyc);
      ofmap_size = (cyc == restart_cyc) ? 16'd3 : 16'(size);
      pready_i   = (pmode == 1) ? cyc[0] : 1'b1;
      lane_valid_i = (widx < words.size());
      lane_psum_i  = lane_valid_i ? words[widx] : 32'd0;
      if (rst_beat >= 0 && beats == rst_beat) begin
        chk_en = 0;
        rst    = 1'b1;
        #1;
        chk("rst_pvalid", pvalid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        lane_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_pvalid_next", pvalid_o, 1'b0);
        exp_q.delete();
        return;
      end
    end
    lane_valid_i = 1'b0;
    start_i      = 1'b0;
    chk("frame_done", got, 1'b1);
    chk("leftover", exp_q.size(), 0);
    chk("done_cnt", done_cnt, 1);
  endtask

  task automatic load_seq16();
    words.delete();
    for (int i = 0; i < 4; i++)
      words.push_back(mkw(8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psum", psum_o, 8'h00);
    chk("rst_pvalid", pvalid_o, 1'b0);
    chk("rst_ready", lane_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_plast", plast_o, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: full-rate, two channels of eight pixels
    load_seq16();
    run_frame(7, 1, 0, -1, -1);
    chk("s1_beats", beats, 16);
    chk("s1_first", first_val, 8'd0);
    chk("s1_last", last_val, 8'd15);
    chk("s1_words", acc_cnt, 4);
    chk("idle_ready", lane_ready_o, 1'b0);

    // 2: six pixels per channel, partial second words carry garbage lanes
    words.delete();
    words.push_back(mkw(8'd0, 8'd1, 8'd2, 8'd3));
    words.push_back(mkw(8'd4, 8'd5, 8'hEE, 8'hEE));
    words.push_back(mkw(8'd6, 8'd7, 8'd8, 8'd9));
    words.push_back(mkw(8'd10, 8'd11, 8'hEE, 8'hEE));
    run_frame(5, 1, 0, -1, -1);
    chk("s2_beats", beats, 12);
    chk("s2_last", last_val, 8'd11);
    chk("s2_words", acc_cnt, 4);

    // 3: backpressure every other cycle
    load_seq16();
    run_frame(7, 1, 1, -1, -1);
    chk("s3_beats", beats, 16);
    chk("s3_last", last_val, 8'd15);

    // 4: single-psum frame
    words.delete();
    words.push_back(mkw(8'h80, 8'd5, 8'd5, 8'd5));
    run_frame(0, 0, 0, -1, -1);
    chk("s4_beats", beats, 1);
    chk("s4_val", first_val, 8'h80);

    // 5: reset on the third beat, then a clean replay
    load_seq16();
    run_frame(7, 1, 0, 2, -1);
    repeat (2) @(posedge clk);
    run_frame(7, 1, 0, -1, -1);
    chk("s5_beats", beats, 16);
    chk("s5_first", first_val, 8'd0);

    // 6: start pulsed while busy is ignored
    run_frame(7, 1, 0, -1, 6);
    chk("s6_beats", beats, 16);
    chk("s6_last", last_val, 8'd15);
`ifdef PSUM_STREAMER_LAST_EN
    chk("s6_plast_cnt", plast_cnt, 2);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
